// File: rtl/if_id_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the
// synchronous-read instruction SRAM (slave).
interface if_id_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            im_cs;
  logic [XLEN-1:0] im_addr;
  logic [31:0]     im_rdata;

  modport master (output im_cs, output im_addr, input im_rdata);
  modport slave  (input im_cs, input im_addr, output im_rdata);
endinterface

// File: rtl/if_id_stage.sv
// RV32 instruction-fetch stage and IF/ID pipeline register: owns the PC,
// drives the instruction SRAM, applies load-use stalls and EX redirects.
module if_id_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  if_id_stage_if.master   im,
  output logic [XLEN-1:0] if_pc,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [31:0]     id_inst
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;
  logic            id_valid_q;
  logic [XLEN-1:0] id_pc_q;
  logic [XLEN-1:0] id_pc_plus4_q;
  logic [31:0]     id_inst_q;

  assign pc_plus4 = pc_q + XLEN'(4);

  // Redirect beats stall; the SRAM sees RESET_PC during reset so its data
  // is ready on the first post-reset cycle.
  always_comb begin
    next_pc = pc_plus4;
    if (redirect) begin
      next_pc = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (stall) begin
      next_pc = pc_q;
    end
  end

  assign im.im_cs   = 1'b1;
  assign im.im_addr = rst_n ? next_pc : RESET_PC;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= next_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || redirect) begin
      id_valid_q    <= 1'b0;
      id_pc_q       <= '0;
      id_pc_plus4_q <= XLEN'(4);
      id_inst_q     <= NOP_INST;
    end else if (!stall) begin
      id_valid_q    <= 1'b1;
      id_pc_q       <= pc_q;
      id_pc_plus4_q <= pc_plus4;
      id_inst_q     <= im.im_rdata;
    end
  end

  assign if_pc       = pc_q;
  assign id_valid    = id_valid_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_inst     = id_inst_q;

endmodule
